// File: rtl/lstm_pkg.sv
// Shared LSTM host/core definitions: default widths and the loader FSM state type.
package lstm_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned AddrWidth = 12;
  localparam int unsigned LenWidth  = 10;
  localparam int unsigned StepWidth = 8;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry data+last buffer. Head entry drives the outputs; push and pop may coincide.
module skid_fifo2 import lstm_pkg::*; #(
  parameter int unsigned DWIDTH = DataWidth
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  // Entries stored as {last, data}.
  logic [DWIDTH:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            do_pop, do_push;
  logic [DWIDTH:0] new_ent;

  // Next-state of entries and count.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    new_ent = {push_last, push_data};
    do_pop  = pop && (cnt_q != 2'd0);
    // A push into a full buffer is dropped unless a pop frees a slot.
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    unique case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = ent0_q[DWIDTH-1:0];
  assign head_last = ent0_q[DWIDTH];
  assign count     = cnt_q;

endmodule

// File: rtl/seq_loader.sv
// Streams steps*len words from base_addr onward out of word memory as a valid/ready
// stream, flagging the last element of each timestep vector, then pulses ack.
module seq_loader import lstm_pkg::*; #(
  parameter int unsigned DWIDTH = DataWidth,
  parameter int unsigned AWIDTH = AddrWidth,
  parameter int unsigned LWIDTH = LenWidth,
  parameter int unsigned TWIDTH = StepWidth
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [LWIDTH-1:0] len,
  input  logic [TWIDTH-1:0] steps,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              ack
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [LWIDTH-1:0] len_q, len_d, elem_q, elem_d;
  logic [TWIDTH-1:0] steps_q, steps_d, step_q, step_d;
  logic              inflight_q, inflight_d;
  logic              fl_last_q, fl_last_d;

  logic [1:0] buf_count;
  logic [2:0] occupancy;
  logic       pop, room, accept, degenerate;
  logic       elem_last, step_last, drain_done;

  skid_fifo2 #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk       (clk),
    .xrst      (xrst),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .push_last (fl_last_q),
    .pop       (pop),
    .head_data (out_data),
    .head_last (out_last),
    .count     (buf_count)
  );

  assign out_valid  = (buf_count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign mem_addr   = addr_q;
  assign accept     = (state_q == S_WAIT) && req;
  assign degenerate = (len == '0) || (steps == '0);
  assign elem_last  = (elem_q == len_q - LWIDTH'(1));
  assign step_last  = (step_q == steps_q - TWIDTH'(1));
  // The word leaving this cycle frees its slot, so a steady stream can issue every cycle
  // while buffer plus in-flight read still never exceeds two entries.
  assign occupancy  = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign room       = (occupancy < 3'd2);
  // Buffer empties this cycle with nothing returning from memory.
  assign drain_done = !inflight_q && (buf_count == {1'b0, pop});

  // FSM state register.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (req) state_d = degenerate ? S_DONE : S_READ;
      S_READ:  if (mem_re && elem_last && step_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_DONE;
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mem_re = 1'b0;
    busy   = 1'b0;
    ack    = 1'b0;
    unique case (state_q)
      S_WAIT:  ;
      S_READ:  begin busy = 1'b1; mem_re = room; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  begin busy = 1'b1; ack = 1'b1; end
      default: ;
    endcase
  end

  // Job parameters, element/timestep counters and the address incrementer.
  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    steps_d    = steps_q;
    elem_d     = elem_q;
    step_d     = step_q;
    inflight_d = mem_re;
    fl_last_d  = mem_re ? elem_last : fl_last_q;
    if (accept) begin
      addr_d  = base_addr;
      len_d   = len;
      steps_d = steps;
      elem_d  = '0;
      step_d  = '0;
    end else if (mem_re) begin
      addr_d = addr_q + AWIDTH'(1);
      if (elem_last) begin
        elem_d = '0;
        step_d = step_q + TWIDTH'(1);
      end else begin
        elem_d = elem_q + LWIDTH'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      addr_q     <= '0;
      len_q      <= '0;
      steps_q    <= '0;
      elem_q     <= '0;
      step_q     <= '0;
      inflight_q <= 1'b0;
      fl_last_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      steps_q    <= steps_d;
      elem_q     <= elem_d;
      step_q     <= step_d;
      inflight_q <= inflight_d;
      fl_last_q  <= fl_last_d;
    end
  end

endmodule
